dvi_video_timing_ctrl: RTL



---
 rtl/dvi_video_timing_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dvi_video_timing_ctrl.sv
// Raster timing sequencer for the DVI output path: runs h/v counters, locks an
// upstream valid/ready pixel stream to start-of-frame and recovers from underflow.
module dvi_video_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic        i_pix_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [23:0] i_s_data,
  input  logic        i_s_valid,
  input  logic        i_s_user,
  output logic        o_s_ready,
  output logic        o_de,
  output logic [7:0]  o_data_ch0,
  output logic [7:0]  o_data_ch1,
  output logic [7:0]  o_data_ch2,
  output logic [1:0]  o_ctrl_ch0,
  output logic [1:0]  o_ctrl_ch1,
  output logic [1:0]  o_ctrl_ch2,
  output logic        o_locked,
  output logic        o_underflow,
  output logic [15:0] o_underflow_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          active, hs, vs, h_wrap, frame_end, sof_pend, at_origin;
  logic          ready, accept, ufl;

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs        = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs        = (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign h_wrap    = (h_cnt == H_LAST);
  assign frame_end = h_wrap && (v_cnt == V_LAST);
  assign sof_pend  = i_s_valid && i_s_user;
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  assign o_s_ready  = ready;
  assign o_locked   = (state == RUN);
  assign o_ctrl_ch1 = 2'b00;
  assign o_ctrl_ch2 = 2'b00;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    ufl       = 1'b0;
    unique case (state)
      IDLE: if (i_enable) state_nxt = SYNC;
      SYNC: begin
        // drain non-SOF beats, hold the SOF beat until the raster wraps
        ready = !sof_pend;
        if (frame_end) begin
          if (!i_enable)     state_nxt = IDLE;
          else if (sof_pend) state_nxt = RUN;
        end
      end
      RUN: begin
        // a SOF anywhere but the origin is left in place for the next frame
        ready = active && !(sof_pend && !at_origin);
        ufl   = active && (!i_s_valid || (sof_pend && !at_origin) ||
                           (i_s_valid && at_origin && !i_s_user));
        if (ufl)                       state_nxt = SYNC;
        else if (frame_end && !i_enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == RUN) && i_s_valid && ready;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (state == IDLE || state_nxt == IDLE) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h_wrap) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_nxt = h_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      h_cnt           <= '0;
      v_cnt           <= '0;
      o_de            <= 1'b0;
      o_data_ch0      <= '0;
      o_data_ch1      <= '0;
      o_data_ch2      <= '0;
      o_ctrl_ch0      <= {~V_POL, ~H_POL};
      o_underflow     <= 1'b0;
      o_underflow_cnt <= '0;
    end else begin
      state       <= state_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      o_de        <= active && (state != IDLE);
      {o_data_ch2, o_data_ch1, o_data_ch0} <= accept ? i_s_data : 24'd0;
      o_ctrl_ch0  <= (state == IDLE) ? {~V_POL, ~H_POL}
                                     : {vs ? V_POL : ~V_POL, hs ? H_POL : ~H_POL};
      o_underflow <= ufl;
      if (ufl && o_underflow_cnt != 16'hFFFF)
        o_underflow_cnt <= o_underflow_cnt + 16'd1;
    end
  end
endmodule
